// File: rtl/pcm_feeder.sv
// rtl/pcm_feeder.sv - paced PCM sample FIFO feeding the sigma-delta DAC
//
// Buffers producer samples in a circular FIFO and releases one to the DAC on
// every sample period of divider+1 clocks while enable is high. An empty FIFO
// at release time substitutes the underrun value and sets a sticky flag.
//
// Build option: PCM_FEEDER_HOLD_EN
//   defined   - underrun repeats the last pcm value
//   undefined - underrun outputs midscale (silence)
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_data  producer sample, accepted when in_ready
//   in_ready          FIFO not full
//   enable            run the sample pacer
//   divider           sample period minus one, in clk cycles
//   flush             discard FIFO contents (and any same-cycle push)
//   underrun_clr      clear the sticky underrun flag
//   pcm               registered sample to the DAC
//   sample_strobe     one-cycle pulse on each pcm update
//   level             FIFO occupancy, 0..FIFO_DEPTH
//   underrun          sticky: a release found the FIFO empty
module pcm_feeder #(
  parameter int BITDEPTH   = 14,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [BITDEPTH-1:0]           in_data,
  output logic                          in_ready,
  input  logic                          enable,
  input  logic [DIV_W-1:0]              divider,
  input  logic                          flush,
  input  logic                          underrun_clr,
  output logic [BITDEPTH-1:0]           pcm,
  output logic                          sample_strobe,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          underrun
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [BITDEPTH-1:0] MIDSCALE = {1'b1, {(BITDEPTH-1){1'b0}}};
  localparam logic [LVL_W-1:0]    FULL     = LVL_W'(FIFO_DEPTH);

  logic [BITDEPTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [DIV_W-1:0]    tick_q, tick_d;
  logic [BITDEPTH-1:0] pcm_q, pcm_d;
  logic                strobe_q, strobe_d;
  logic                underrun_q, underrun_d;

  logic pop_ev;
  logic push;
  logic pop;
  logic starve;
  logic [BITDEPTH-1:0] underrun_val;

`ifdef PCM_FEEDER_HOLD_EN
  assign underrun_val = pcm_q;
`else
  assign underrun_val = MIDSCALE;
`endif

  assign in_ready      = (level_q != FULL);
  assign pcm           = pcm_q;
  assign sample_strobe = strobe_q;
  assign level         = level_q;
  assign underrun      = underrun_q;

  always_comb begin
    pop_ev = enable && (tick_q == '0);
    // flush wins over both sides; a release during flush sees an empty FIFO
    push   = in_valid && in_ready && !flush;
    pop    = pop_ev && (level_q != '0) && !flush;
    starve = pop_ev && !pop;

    tick_d     = tick_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    pcm_d      = pcm_q;
    strobe_d   = pop_ev;
    underrun_d = underrun_q;

    // reload on disable and on expiry, so a divider change lands at the next reload
    if (!enable || (tick_q == '0)) begin
      tick_d = divider;
    end else begin
      tick_d = tick_q - DIV_W'(1);
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop) level_d = level_q + LVL_W'(1);
      if (pop && !push) level_d = level_q - LVL_W'(1);
    end

    if (pop) begin
      pcm_d = mem_q[rd_ptr_q];
    end else if (starve) begin
      pcm_d = underrun_val;
    end

    // a new underrun outranks a same-cycle clear
    if (starve) begin
      underrun_d = 1'b1;
    end else if (underrun_clr) begin
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      tick_q     <= divider;
      pcm_q      <= MIDSCALE;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      tick_q     <= tick_d;
      pcm_q      <= pcm_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
    end
  end

  // storage needs no reset; pointers and level define what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_pcm_feeder.sv
// tb/tb_pcm_feeder.sv - scoreboard bench for pcm_feeder against a queue-based reference model
module tb_pcm_feeder;

  localparam int BD  = 14;
  localparam int FD  = 16;
  localparam int DW  = 16;
  localparam int LW  = 5;
  localparam logic [BD-1:0] MID = 14'h2000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [BD-1:0] in_data = '0;
  logic          in_ready;
  logic          enable = 1'b0;
  logic [DW-1:0] divider = '0;
  logic          flush = 1'b0;
  logic          underrun_clr = 1'b0;
  logic [BD-1:0] pcm;
  logic          sample_strobe;
  logic [LW-1:0] level;
  logic          underrun;

  always #5 clk = ~clk;

  pcm_feeder #(.BITDEPTH(BD), .FIFO_DEPTH(FD), .DIV_W(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .enable(enable), .divider(divider), .flush(flush),
    .underrun_clr(underrun_clr), .pcm(pcm), .sample_strobe(sample_strobe),
    .level(level), .underrun(underrun)
  );

  typedef struct {
    bit            strobe;
    logic [BD-1:0] pcm;
    int            level;
    bit            und;
  } cyc_t;

  cyc_t          cyc_q[$];
  logic [BD-1:0] smp_q[$];

  logic [BD-1:0] m_fifo[$];
  logic [BD-1:0] m_pcm = MID;
  bit            m_und = 1'b0;
  int            m_wait = 0;

  int checks = 0;
  int errors = 0;

  bit            s_rst = 1'b1, s_v = 1'b0, s_en = 1'b0, s_fl = 1'b0, s_clr = 1'b0;
  logic [BD-1:0] s_d = '0;
  int            s_dv = 3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and advance the reference model across the next edge.
  task automatic step();
    cyc_t e;
    bit   strobe;
    bit   ready;
    bit   starve;
    @(negedge clk);
    rst = s_rst; in_valid = s_v; in_data = s_d; enable = s_en;
    divider = DW'(s_dv); flush = s_fl; underrun_clr = s_clr;
    strobe = 1'b0;
    if (s_rst) begin
      m_fifo.delete();
      m_pcm  = MID;
      m_und  = 1'b0;
      m_wait = s_dv;
    end else begin
      ready  = (m_fifo.size() < FD);
      strobe = s_en && (m_wait == 0);
      starve = strobe && (s_fl || m_fifo.size() == 0);
      if (starve) begin
`ifndef PCM_FEEDER_HOLD_EN
        m_pcm = MID;
`endif
      end else if (strobe) begin
        m_pcm = m_fifo.pop_front();
      end
      if (starve) m_und = 1'b1;
      else if (s_clr) m_und = 1'b0;
      if (s_fl) m_fifo.delete();
      else if (s_v && ready) m_fifo.push_back(s_d);
      // edges remaining until the next release; a new period length is picked up at each restart
      if (!s_en || m_wait == 0) m_wait = s_dv;
      else m_wait = m_wait - 1;
    end
    e.strobe = strobe;
    e.pcm    = m_pcm;
    e.level  = m_fifo.size();
    e.und    = m_und;
    cyc_q.push_back(e);
    if (strobe) smp_q.push_back(m_pcm);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic push(input logic [BD-1:0] d);
    s_v = 1'b1; s_d = d;
    run(1);
    s_v = 1'b0;
  endtask

  // Monitor: compares after each edge, pops the sample queue whenever the DUT strobes.
  initial begin
    cyc_t e;
    forever begin
      @(posedge clk);
      #1;
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        chk("level", 32'(level), 32'(e.level));
        chk("in_ready", 32'(in_ready), 32'(e.level != FD));
        chk("underrun", 32'(underrun), 32'(e.und));
        chk("strobe", 32'(sample_strobe), 32'(e.strobe));
        chk("pcm_hold", 32'(pcm), 32'(e.pcm));
        if (sample_strobe === 1'b1) begin
          if (smp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL strobe_unexpected: got strobe expected none at %0t", $time);
          end else begin
            chk("pcm_sample", 32'(pcm), 32'(smp_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    // reset, then idle with enable low: no strobes, midscale output
    s_rst = 1'b1; s_dv = 3;
    run(2);
    s_rst = 1'b0;
    run(4);

    // pacing with divider 3
    push(14'h0100); push(14'h0200); push(14'h0300);
    s_en = 1'b1;
    run(16);

    // fill to full while paused; 17th push rejected
    s_en = 1'b0; s_clr = 1'b1; run(1); s_clr = 1'b0;
    for (int i = 0; i < 17; i++) push(BD'(i * 16'h0111 + 1));
    s_dv = 0; s_en = 1'b1;
    run(20);

    // underrun after last sample 0x1234
    s_en = 1'b0; s_clr = 1'b1; run(1); s_clr = 1'b0;
    push(14'h1111); push(14'h1234);
    s_dv = 2; s_en = 1'b1;
    run(12);
    s_dv = 0; s_clr = 1'b1;
    run(2);
    s_en = 1'b0;
    run(1);
    s_clr = 1'b0;
    run(2);

    // flush with a simultaneous push
    for (int i = 0; i < 5; i++) push(BD'(16'h0500 + i));
    s_fl = 1'b1; s_v = 1'b1; s_d = 14'h03ff;
    run(1);
    s_fl = 1'b0; s_v = 1'b0;
    run(2);

    // divider change mid-period, then reset mid-period
    for (int i = 0; i < 6; i++) push(BD'(16'h0a00 + i));
    s_dv = 3; s_en = 1'b1;
    run(6);
    s_dv = 7;
    run(20);
    s_rst = 1'b1; run(1); s_rst = 1'b0;
    run(5);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s_rst = ($urandom % 200) == 0;
      s_v   = $urandom % 2;
      s_d   = BD'($urandom);
      s_en  = ($urandom % 8) != 0;
      if (($urandom % 30) == 0) s_dv = $urandom_range(0, 5);
      s_fl  = ($urandom % 60) == 0;
      s_clr = ($urandom % 20) == 0;
      run(1);
    end

    s_rst = 1'b0; s_v = 1'b0; s_en = 1'b0; s_fl = 1'b0; s_clr = 1'b0;
    run(2);
    repeat (4) @(posedge clk);
    #2;
    chk("cyc_q_drained", 32'(cyc_q.size()), 32'd0);
    chk("smp_q_drained", 32'(smp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
